// File: rtl/pipelined_carry_adder_if.sv
// pipelined_carry_adder_if: operand/result valid-ready bus for pipelined_carry_adder
interface pipelined_carry_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit adder with the carry chain cut into STAGES registered chunks, valid/ready on both sides
// Define ADDER_OVF_DETECT_EN to produce the signed-overflow flag; otherwise ovf is tied 0.
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_carry_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : st
    localparam int RW = WIDTH - CW * k;
    localparam int SW = CW * (k + 1);
    logic [RW-1:0] ra, rb;
    logic ci, vi, co;
    logic [CW-1:0] cs;
    logic v_d, v_q, c_d, c_q;
    logic [SW-1:0] si, s_d, s_q;
    if (k == 0) begin : src
      assign ra = bus.a;
      assign rb = bus.b;
      assign ci = bus.cin;
      assign vi = bus.in_valid;
      assign si = cs;
    end else begin : src
      assign ra = st[k-1].skw.a_q;
      assign rb = st[k-1].skw.b_q;
      assign ci = st[k-1].c_q;
      assign vi = st[k-1].v_q;
      assign si = {cs, st[k-1].s_q};
    end
    // ra/rb hold only the chunks not yet added; the low CW bits belong to this stage
    assign {co, cs} = {1'b0, ra[CW-1:0]} + {1'b0, rb[CW-1:0]} + {{CW{1'b0}}, ci};
    always_comb begin
      v_d = adv ? vi : v_q;
      c_d = adv ? co : c_q;
      s_d = adv ? si : s_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end
    if (k < STAGES - 1) begin : skw
      logic [RW-CW-1:0] a_d, a_q, b_d, b_q;
      always_comb begin
        a_d = adv ? ra[RW-1:CW] : a_q;
        b_d = adv ? rb[RW-1:CW] : b_q;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
    if (k == STAGES - 1) begin : last
`ifdef ADDER_OVF_DETECT_EN
      logic o_d, o_q;
      // same-sign operands giving an opposite-sign result == carry-in xor carry-out of the MSB
      always_comb o_d = adv ? (ra[CW-1] == rb[CW-1]) && (cs[CW-1] != ra[CW-1]) : o_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) o_q <= 1'b0;
        else o_q <= o_d;
      end
      assign bus.ovf = o_q;
`else
      assign bus.ovf = 1'b0;
`endif
      assign bus.out_valid = v_q;
      assign bus.sum = s_q;
      assign bus.cout = c_q;
    end
  end
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed checks of the pipelined adder at STAGES=4 and STAGES=1
module tb_pipelined_carry_adder;
  localparam int W = 16;
  localparam int S = 4;
`ifdef ADDER_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  logic [W:0] q[$];
  pipelined_carry_adder_if #(.WIDTH(W)) bus();
  pipelined_carry_adder_if #(.WIDTH(W)) bus1();
  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  pipelined_carry_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b want 0/0000/0/0", bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.sum !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs_s1: got v=%b sum=%h want 0/0000", bus1.out_valid, bus1.sum);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask
  task automatic test_directed();
    logic [15:0] va[5], vb[5], vs[5];
    logic vc[5], vco[5], vo[5];
    int cnt;
    va = '{16'hFFFF, 16'h00FF, 16'h8000, 16'h7FFF, 16'h1234};
    vb = '{16'h0001, 16'h0000, 16'h8000, 16'h0001, 16'h4321};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vs = '{16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'h5556};
    vco = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vo = '{1'b0, 1'b0, OVF_ON, OVF_ON, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.a = va[i];
      bus.b = vb[i];
      bus.cin = vc[i];
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      checks++;
      if (cnt !== S - 1) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d edges after accept want %0d", i, cnt, S - 1);
      end
      checks++;
      if (bus.sum !== vs[i] || bus.cout !== vco[i] || bus.ovf !== vo[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b", i, bus.sum, bus.cout, bus.ovf, vs[i], vco[i], vo[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_single_cycle: out_valid got %b want 0", i, bus.out_valid);
      end
    end
  endtask
  task automatic test_back_to_back();
    int n_in = 0, n_out = 0, first = -1, lastc = -1;
    logic [W:0] got, exp_v;
    q.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && n_out < 16; cyc++) begin
      bus.in_valid = n_in < 16;
      bus.a = 16'(16'hF00D + n_in * 16'h2F1B);
      bus.b = 16'(16'h0FF3 ^ n_in * 16'h1D37);
      bus.cin = n_in[0];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.cout, bus.sum};
        exp_v = q.size() > 0 ? q.pop_front() : 17'h0;
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h want %h", n_out, got, exp_v);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {16'h0, bus.cin});
        n_in++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n_out !== 16 || lastc - first !== 15) begin
      errors++;
      $display("FAIL b2b_stream: got %0d results over %0d cycles want 16 over 16", n_out, lastc - first + 1);
    end
  endtask
  task automatic test_stall();
    int n_in = 0, n_out = 0;
    logic [W:0] held, got, exp_v;
    logic stall;
    q.delete();
    held = '0;
    for (int cyc = 0; cyc < 80 && n_out < 12; cyc++) begin
      stall = cyc >= 6 && cyc < 9;
      bus.out_ready = !stall;
      bus.in_valid = n_in < 12;
      bus.a = 16'(16'h4C3B + n_in * 16'h3A95);
      bus.b = 16'(16'hB3C5 - n_in * 16'h0F0F);
      bus.cin = ~n_in[0];
      #1;
      if (stall) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_c%0d_flags: got in_ready=%b out_valid=%b want 0/1", cyc, bus.in_ready, bus.out_valid);
        end
        if (cyc == 6) held = {bus.cout, bus.sum};
        else begin
          checks++;
          if ({bus.cout, bus.sum} !== held) begin
            errors++;
            $display("FAIL stall_c%0d_stable: got %h want %h", cyc, {bus.cout, bus.sum}, held);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.cout, bus.sum};
        exp_v = q.size() > 0 ? q.pop_front() : 17'h0;
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL stall_result%0d: got %h want %h", n_out, got, exp_v);
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {16'h0, bus.cin});
        n_in++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (n_out !== 12 || q.size() !== 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results, %0d pending want 12, 0", n_out, q.size());
    end
  endtask
  task automatic test_reset_in_flight();
    int stale = 0, cnt = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.cin = 1'b1;
    bus.b = 16'h0101;
    for (int i = 0; i < 6; i++) begin
      bus.a = 16'(16'h1111 * (i + 1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h1213 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: got v=%b sum=%h c=%b want 1/1213/0", bus.out_valid, bus.sum, bus.cout);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.cout !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got v=%b sum=%h c=%b rdy=%b want 0/0000/0/1", bus.out_valid, bus.sum, bus.cout, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL rst_stale: got %0d stale results want 0", stale);
    end
    bus.a = 16'h0F0F;
    bus.b = 16'h00F1;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checks++;
    if (cnt !== S - 1 || bus.sum !== 16'h1000 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got lat=%0d sum=%h c=%b want %0d/1000/0", cnt, bus.sum, bus.cout, S - 1);
    end
  endtask
  task automatic test_stages1();
    bus1.a = 16'hFFFF;
    bus1.b = 16'h0001;
    bus1.cin = 1'b0;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.sum !== 16'h0000 || bus1.cout !== 1'b1) begin
      errors++;
      $display("FAIL s1_latency: got v=%b sum=%h c=%b want 1/0000/1 one edge after accept", bus1.out_valid, bus1.sum, bus1.cout);
    end
    bus1.a = 16'h7FFF;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.sum !== 16'h8000 || bus1.ovf !== OVF_ON) begin
      errors++;
      $display("FAIL s1_ovf: got v=%b sum=%h o=%b want 1/8000/%b", bus1.out_valid, bus1.sum, bus1.ovf, OVF_ON);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL s1_drain: out_valid got %b want 0", bus1.out_valid);
    end
  endtask
  initial begin
    rst = 1'b1;
    {bus.in_valid, bus.a, bus.b, bus.cin} = '0;
    bus.out_ready = 1'b1;
    {bus1.in_valid, bus1.a, bus1.b, bus1.cin} = '0;
    bus1.out_ready = 1'b1;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
    test_stages1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
